fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
//  Output reordering buffer for the 4-lane parallel FFT pipeline. Sits directly downstream of
//  the stage-3/4 butterfly + Sat1 saturator block, consuming its four 2*NBITS_out-bit complex lanes
//  and their o_enable. Collects one N-point frame in bit-reversed order and replays it in
//  natural order, four bins per cycle. Uses a ping-pong pair of register banks for continuous throughput.
// PARAMETERS
//  NBITS_out  19   bits per real/imag component (sample word = 2*NBITS_out, {re,im} passed untouched)
//  N          128  FFT length; power of 2, >=16
//  LOG2N      7    log2(N); must match N
// PORTS
//  clk            input   1             rising-edge clock
//  rst            input   1             asynchronous, active-low reset
//  fftIn0_up      input   2*NBITS_out   lane 0 sample
//  fftIn0_down    input   2*NBITS_out   lane 1 sample
//  fftIn1_up      input   2*NBITS_out   lane 2 sample
//  fftIn1_down    input   2*NBITS_out   lane 3 sample
//  in_enable      input   1             input beat valid (upstream o_enable)
//  fftOut0        output  2*NBITS_out   natural-order bin 4j+0
//  fftOut1        output  2*NBITS_out   natural-order bin 4j+1
//  fftOut2        output  2*NBITS_out   natural-order bin 4j+2
//  fftOut3        output  2*NBITS_out   natural-order bin 4j+3
//  o_enable       output  1             output beat valid
//  o_frame_start  output  1             high on first beat (j=0) of each output frame
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0. Write counter wcnt=0, read counter rcnt=0, wbank=0,
//    reader IDLE. Bank contents are not cleared. A partial frame in progress is discarded.
//  - Frame = N/4 beats. A beat is a rising edge with in_enable=1. Beat k (0..N/4-1), lane l
//    (0..3, order 0_up,0_down,1_up,1_down) is written to bank[wbank][bitrev_LOG2N(4k+l)].
//  - in_enable=0 mid-frame: wcnt holds, nothing written. Gaps of any length are allowed.
//  - On the edge that writes beat N/4-1: wcnt->0, wbank toggles, and the filled bank becomes
//    the read bank. The reader enters RUN with rcnt=0.
//  - Reader FSM: IDLE -> RUN on frame completion. RUN -> IDLE when rcnt=N/4-1 and no new
//    frame completes on the same edge. In RUN, each edge registers
//    fftOutl = bank[rbank][4*rcnt+l], o_enable=1, o_frame_start=(rcnt==0), then rcnt++.
//  - Latency: the first output beat is valid one clock after the completion edge.
//    If completion is at edge E, o_enable=1 from edge E+1 through E+N/4 inclusive.
//  - Back-to-back frames (in_enable held high): the next completion coincides with the reader's
//    last beat. The reader restarts at rcnt=0 on the other bank. o_enable stays continuously 1;
//    o_frame_start pulses every N/4 beats. Writes never target the bank being read.
//  - Outside RUN: o_enable=0 and o_frame_start=0. fftOut0..3 hold their last values.
//  - No arithmetic: data words are moved bit-exact, with no rounding or saturation.
//  - Storage is a register array (2 banks x N words). Four write ports and four read ports
//    per cycle. No RAM macros.
// TESTING
//  1) Reset, then one frame where input index i=bitrev(4k+l) carries value {re=i,im=-i}
//     -> 32 output beats with fftOutl = {4j+l, -(4j+l)}. o_frame_start only at j=0.
//     First o_enable exactly 1 clk after the last input beat.
//  2) Impulse: only beat 0 lane 0 is nonzero (0x12345 re), all else 0
//     -> only output beat 0 fftOut0 = 0x12345 re. All other bins are 0.
//  3) Stall: the frame from test 1 with in_enable low for 5 cycles after beats 3 and 20
//     -> identical output data. o_enable starts 1 clk after the final (delayed) beat.
//  4) Three back-to-back frames with distinct ramps (offsets 0, 1000, 2000)
//     -> 96 consecutive o_enable=1 beats, correct data per frame.
//     o_frame_start at beats 0, 32 and 64.
//  5) Assert rst=0 asynchronously at input beat 17, release, then send a full frame
//     -> outputs go to 0 immediately. No output from the aborted frame.
//     The new frame reorders correctly.
//  6) Parameter N=16, LOG2N=4: rerun test 1 -> 4 output beats, bins 0..15 in natural order.

Source files
------------

// File: rtl/fft_out_reorder_if.sv
// Lane bundle between the stage-3/4 saturator and the output reorder buffer.
// The producer side (upstream FFT stage) uses master and the reorder buffer uses slave.
interface fft_out_reorder_if #(
   parameter int NBITS_out = 19
);
   logic [2*NBITS_out-1:0] fftIn0_up;
   logic [2*NBITS_out-1:0] fftIn0_down;
   logic [2*NBITS_out-1:0] fftIn1_up;
   logic [2*NBITS_out-1:0] fftIn1_down;
   logic                   in_enable;
   logic [2*NBITS_out-1:0] fftOut0;
   logic [2*NBITS_out-1:0] fftOut1;
   logic [2*NBITS_out-1:0] fftOut2;
   logic [2*NBITS_out-1:0] fftOut3;
   logic                   o_enable;
   logic                   o_frame_start;

   modport master (
      output fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, in_enable,
      input  fftOut0, fftOut1, fftOut2, fftOut3, o_enable, o_frame_start
   );

   modport slave (
      input  fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, in_enable,
      output fftOut0, fftOut1, fftOut2, fftOut3, o_enable, o_frame_start
   );
endinterface

// File: rtl/fft_out_reorder.sv
// Output reorder buffer for the 4-lane FFT: captures a frame in bit-reversed
// order into one register bank while the other bank is replayed in natural
// order, four bins per beat.
module fft_out_reorder #(
   parameter int NBITS_out = 19,
   parameter int N         = 128,
   parameter int LOG2N     = 7
) (
   input  logic             clk,
   input  logic             rst,
   fft_out_reorder_if.slave bus
);
   localparam int W  = 2*NBITS_out;
   localparam int CW = LOG2N-2;
   localparam logic [CW-1:0] LAST = CW'(N/4-1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         wcnt_q, wcnt_d;
   logic [CW-1:0]         rcnt_q, rcnt_d;
   logic                  wbank_q, wbank_d;
   logic                  rbank_q, rbank_d;
   logic [3:0][W-1:0]     dout_q, dout_d;
   logic                  oen_q, oen_d;
   logic                  ofs_q, ofs_d;
   logic [W-1:0]          mem_q [2][N];
   logic [3:0][W-1:0]     din;
   logic                  done;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   assign din[0] = bus.fftIn0_up;
   assign din[1] = bus.fftIn0_down;
   assign din[2] = bus.fftIn1_up;
   assign din[3] = bus.fftIn1_down;

   // The last beat of a frame hands the filled bank over to the reader
   assign done = bus.in_enable && (wcnt_q == LAST);

   // Bank storage: four scattered writes per beat into the write bank; not reset
   always_ff @(posedge clk) begin
      if (rst && bus.in_enable)
         for (int l = 0; l < 4; l++)
            mem_q[wbank_q][bitrev({wcnt_q, l[1:0]})] <= din[l];
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         dout_q  <= '0;
         oen_q   <= 1'b0;
         ofs_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         dout_q  <= dout_d;
         oen_q   <= oen_d;
         ofs_q   <= ofs_d;
      end
   end

   // Next state: writer counter/bank swap and reader FSM with natural-order reads.
   // A completion on the reader's last beat restarts it on the freshly filled bank.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      wbank_d = wbank_q;
      rcnt_d  = rcnt_q;
      rbank_d = rbank_q;
      dout_d  = dout_q;
      oen_d   = 1'b0;
      ofs_d   = 1'b0;

      if (bus.in_enable) wcnt_d = wcnt_q + CW'(1);

      if (state_q == RUN) begin
         for (int l = 0; l < 4; l++) dout_d[l] = mem_q[rbank_q][{rcnt_q, l[1:0]}];
         oen_d  = 1'b1;
         ofs_d  = (rcnt_q == '0);
         rcnt_d = rcnt_q + CW'(1);
         if (rcnt_q == LAST) state_d = IDLE;
      end

      if (done) begin
         wcnt_d  = '0;
         wbank_d = ~wbank_q;
         rbank_d = wbank_q;
         rcnt_d  = '0;
         state_d = RUN;
      end
   end

   assign bus.fftOut0       = dout_q[0];
   assign bus.fftOut1       = dout_q[1];
   assign bus.fftOut2       = dout_q[2];
   assign bus.fftOut3       = dout_q[3];
   assign bus.o_enable      = oen_q;
   assign bus.o_frame_start = ofs_q;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: N=128 instance for the main tests,
// N=16 instance for the small-frame case.
module tb_fft_out_reorder;
   localparam int NB = 19;
   localparam int W  = 2*NB;

   typedef struct packed {
      logic [3:0][W-1:0] d;
      logic              fs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fft_out_reorder_if #(.NBITS_out(NB)) b0();
   fft_out_reorder_if #(.NBITS_out(NB)) b1();

   fft_out_reorder #(.NBITS_out(NB), .N(128), .LOG2N(7)) u0 (.clk(clk), .rst(rst), .bus(b0));
   fft_out_reorder #(.NBITS_out(NB), .N(16),  .LOG2N(4)) u1 (.clk(clk), .rst(rst), .bus(b1));

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int checks = 0;
   int errors = 0;
   int run0 = 0, last_run0 = 0;
   int run1 = 0, last_run1 = 0;

   function automatic logic [W-1:0] mk(input int v);
      int nv;
      nv = -v;
      return {v[NB-1:0], nv[NB-1:0]};
   endfunction

   function automatic int brev(input int v, input int bits);
      int r;
      r = 0;
      for (int i = 0; i < bits; i++) if (v[i]) r = r | (1 << (bits-1-i));
      return r;
   endfunction

   // Input value at natural index i (ramp with offset, or impulse at index 0)
   function automatic logic [W-1:0] val(input int i, input int off, input bit imp);
      logic [W-1:0] impw;
      impw = {19'h12345, 19'h00000};
      if (imp) return (i == 0) ? impw : '0;
      return mk(i + off);
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int sel, input logic [3:0][W-1:0] w, input logic en);
      if (sel == 0) begin
         b0.fftIn0_up = w[0]; b0.fftIn0_down = w[1];
         b0.fftIn1_up = w[2]; b0.fftIn1_down = w[3];
         b0.in_enable = en;
      end else begin
         b1.fftIn0_up = w[0]; b1.fftIn0_down = w[1];
         b1.fftIn1_up = w[2]; b1.fftIn1_down = w[3];
         b1.in_enable = en;
      end
   endtask

   function automatic logic oen(input int sel);
      return (sel == 0) ? b0.o_enable : b1.o_enable;
   endfunction

   // Send one frame; stalls of 5 idle cycles after beats s1/s2; abort asserts reset at beat ab
   task automatic send(input int sel, input int off, input bit imp, input int s1, input int s2,
                       input bit push, input int ab);
      int nn, lg;
      exp_t e;
      logic [3:0][W-1:0] w;
      nn = (sel == 0) ? 128 : 16;
      lg = (sel == 0) ? 7 : 4;
      if (push)
         for (int j = 0; j < nn/4; j++) begin
            for (int l = 0; l < 4; l++) e.d[l] = val(4*j+l, off, imp);
            e.fs = (j == 0);
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
         end
      for (int k = 0; k < nn/4; k++) begin
         for (int l = 0; l < 4; l++) w[l] = val(brev(4*k+l, lg), off, imp);
         @(negedge clk);
         drive(sel, w, 1'b1);
         if (k == ab) begin
            #2 rst = 1'b0;
            return;
         end
         if (k == s1 || k == s2)
            repeat (5) begin
               @(negedge clk);
               drive(sel, w, 1'b0);
            end
      end
   endtask

   // Drop enable; optionally check the first output beat lands exactly one clock after completion
   task automatic idle_lat(input int sel, input bit do_lat);
      @(negedge clk);
      drive(sel, '0, 1'b0);
      if (do_lat) chk("lat_early", W'(oen(sel)), W'(0));
      @(negedge clk);
      if (do_lat) chk("lat_first", W'(oen(sel)), W'(1));
   endtask

   task automatic drain(input int sel);
      int t;
      t = 0;
      while (((sel == 0) ? q0.size() : q1.size()) != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk("drain", W'((sel == 0) ? q0.size() : q1.size()), W'(0));
   endtask

   // Monitor for the N=128 instance
   always @(negedge clk) begin
      if (!rst) run0 = 0;
      else if (b0.o_enable) begin
         run0++;
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexp_beat0 act=o_enable=1 exp=o_enable=0 t=%0t", $time);
         end else begin
            e0 = q0.pop_front();
            chk("u0_out0", b0.fftOut0, e0.d[0]);
            chk("u0_out1", b0.fftOut1, e0.d[1]);
            chk("u0_out2", b0.fftOut2, e0.d[2]);
            chk("u0_out3", b0.fftOut3, e0.d[3]);
            chk("u0_fs", W'(b0.o_frame_start), W'(e0.fs));
         end
      end else begin
         if (run0 != 0) last_run0 = run0;
         run0 = 0;
         chk("u0_fs_idle", W'(b0.o_frame_start), W'(0));
      end
   end

   // Monitor for the N=16 instance
   always @(negedge clk) begin
      if (!rst) run1 = 0;
      else if (b1.o_enable) begin
         run1++;
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexp_beat1 act=o_enable=1 exp=o_enable=0 t=%0t", $time);
         end else begin
            e1 = q1.pop_front();
            chk("u1_out0", b1.fftOut0, e1.d[0]);
            chk("u1_out1", b1.fftOut1, e1.d[1]);
            chk("u1_out2", b1.fftOut2, e1.d[2]);
            chk("u1_out3", b1.fftOut3, e1.d[3]);
            chk("u1_fs", W'(b1.o_frame_start), W'(e1.fs));
         end
      end else begin
         if (run1 != 0) last_run1 = run1;
         run1 = 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end

   initial begin
      drive(0, '0, 1'b0);
      drive(1, '0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_oen", W'(b0.o_enable), W'(0));
      chk("rst_fs", W'(b0.o_frame_start), W'(0));
      chk("rst_out0", b0.fftOut0, '0);
      chk("rst_out3", b0.fftOut3, '0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Ramp frame
      send(0, 0, 1'b0, -1, -1, 1'b1, -1);
      idle_lat(0, 1'b1);
      drain(0);
      chk("run_t1", W'(last_run0), W'(32));
      chk("hold_out3", b0.fftOut3, mk(127));

      // Impulse
      send(0, 0, 1'b1, -1, -1, 1'b1, -1);
      idle_lat(0, 1'b1);
      drain(0);

      // Stalls after beats 3 and 20
      send(0, 0, 1'b0, 3, 20, 1'b1, -1);
      idle_lat(0, 1'b1);
      drain(0);
      chk("run_t3", W'(last_run0), W'(32));

      // Three back-to-back frames
      send(0, 0,    1'b0, -1, -1, 1'b1, -1);
      send(0, 1000, 1'b0, -1, -1, 1'b1, -1);
      send(0, 2000, 1'b0, -1, -1, 1'b1, -1);
      idle_lat(0, 1'b0);
      drain(0);
      chk("run_t4", W'(last_run0), W'(96));

      // Reset mid-frame at beat 17, then a clean frame
      send(0, 0, 1'b0, -1, -1, 1'b0, 17);
      #1;
      chk("arst_oen", W'(b0.o_enable), W'(0));
      chk("arst_out0", b0.fftOut0, '0);
      chk("arst_out1", b0.fftOut1, '0);
      chk("arst_out2", b0.fftOut2, '0);
      chk("arst_out3", b0.fftOut3, '0);
      @(negedge clk);
      drive(0, '0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      send(0, 500, 1'b0, -1, -1, 1'b1, -1);
      idle_lat(0, 1'b1);
      drain(0);
      chk("run_t5", W'(last_run0), W'(32));

      // N=16 instance
      send(1, 0, 1'b0, -1, -1, 1'b1, -1);
      idle_lat(1, 1'b1);
      drain(1);
      chk("run_t6", W'(last_run1), W'(4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
